onehot_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource between N_REQ requesters and drives the one-hot select of an AND-OR `onehot_mux` feeding that resource. Grants are registered and held for a whole transaction, until the resource signals completion or a hold watchdog expires. The block sits in front of shared bus slaves and shared datapath units, with `gnt` wired directly to the mux `sel`.

---
 rtl/onehot_rr_arbiter_if.sv | 24 ++
 rtl/onehot_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_rr_arbiter_if.sv
// Handshake bundle between the requesters/resource and the round-robin arbiter.
// The arbiter sits on the slave side. The requesters and the resource drive
// req/done from the master side.
interface onehot_rr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W_IDX = $clog2(N_REQ)
);
   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic [W_IDX-1:0] gnt_idx;
   logic             timeout;

   modport master (
      output req, done,
      input  gnt, gnt_valid, gnt_idx, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_valid, gnt_idx, timeout
   );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, held for a whole transaction.
// A grant is released by done, or by an optional hold watchdog.
// On release the arbiter re-arbitrates in the same edge, so handover has no idle bubble.
// gnt feeds the select input of an AND-OR one-hot mux directly.
module onehot_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 0,
   parameter int W_IDX    = $clog2(N_REQ),
   parameter int W_CNT    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input logic                clk,
   input logic                rst,
   onehot_rr_arbiter_if.slave bus
);
   // One extra bit so that ptr + offset can exceed N_REQ before the wrap.
   localparam int W_SUM     = W_IDX + 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_n;
   logic [N_REQ-1:0] gnt_q, gnt_n;
   logic             gnt_valid_q;
   logic [W_IDX-1:0] gnt_idx_q, gnt_idx_n;
   logic [W_IDX-1:0] ptr_q, ptr_n;
   logic [W_CNT-1:0] cnt_q, cnt_n;
   logic             timeout_q, timeout_n;

   logic             win_found;
   logic [W_IDX-1:0] win_idx;
   logic [W_IDX-1:0] win_ptr;
   logic [W_SUM-1:0] sum;
   logic             expire;

   // Find the first requester at or after ptr, wrapping modulo N_REQ.
   // The loop runs from the highest offset down, so the lowest offset wins.
   // NOTE: every variable written here gets a default first; a path that skips an assignment would infer a latch.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = W_SUM'(ptr_q) + W_SUM'(k);
         if (sum >= W_SUM'(N_REQ)) begin
            sum = sum - W_SUM'(N_REQ);
         end
         if (bus.req[sum[W_IDX-1:0]]) begin
            win_found = 1'b1;
            win_idx   = sum[W_IDX-1:0];
         end
      end
   end

   // The pointer moves one past the winner, so the winner has the lowest priority in the next round.
   assign win_ptr = (win_idx == W_IDX'(N_REQ - 1)) ? '0 : win_idx + W_IDX'(1);

   // The watchdog fires on the MAX_HOLD-th edge after the grant that has no done.
   assign expire = (MAX_HOLD > 0) && (cnt_q == W_CNT'(HOLD_LAST));

   // Next-state logic: grant from IDLE, hold while busy, release and re-arbitrate on done or expiry.
   always_comb begin
      state_n   = state_q;
      gnt_n     = gnt_q;
      gnt_idx_n = gnt_idx_q;
      ptr_n     = ptr_q;
      cnt_n     = cnt_q;
      timeout_n = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_n        = BUSY;
               gnt_n          = '0;
               gnt_n[win_idx] = 1'b1;
               gnt_idx_n      = win_idx;
               ptr_n          = win_ptr;
               cnt_n          = '0;
            end
         end
         BUSY: begin
            if (bus.done || expire) begin
               // When done and expiry coincide, done wins and there is no timeout pulse.
               timeout_n = ~bus.done;
               if (win_found) begin
                  gnt_n          = '0;
                  gnt_n[win_idx] = 1'b1;
                  gnt_idx_n      = win_idx;
                  ptr_n          = win_ptr;
                  cnt_n          = '0;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt_q + W_CNT'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   // State and output registers; all clear asynchronously on reset.
   // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_n;
         gnt_q       <= gnt_n;
         gnt_valid_q <= |gnt_n;
         gnt_idx_q   <= gnt_idx_n;
         ptr_q       <= ptr_n;
         cnt_q       <= cnt_n;
         timeout_q   <= timeout_n;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter.
// It runs directed scenarios on a 4-requester arbiter with a 5-cycle watchdog.
// It then runs a randomized comparison against a transaction-level model.
// The random run uses that arbiter and a 5-requester one without a watchdog.
`timescale 1ns/1ps
module tb_onehot_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   onehot_rr_arbiter_if #(.N_REQ(4)) bus_a ();
   onehot_rr_arbiter_if #(.N_REQ(5)) bus_b ();

   onehot_rr_arbiter #(.N_REQ(4), .MAX_HOLD(5)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   onehot_rr_arbiter #(.N_REQ(5), .MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;

   // Reference model: who holds the resource, the search origin, edges held.
   typedef struct {
      bit busy;
      int holder;
      int ptr;
      int cnt;
      bit to;
   } mdl_t;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.busy = 0; m.holder = 0; m.ptr = 0; m.cnt = 0; m.to = 0;
      return m;
   endfunction

   function automatic int pick(int n, int p, bit [7:0] r);
      for (int k = 0; k < n; k++) begin
         if (r[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int n, int max_hold, bit [7:0] r, bit d);
      mdl_t s = m;
      int   w = pick(n, m.ptr, r);
      bit   rel;
      s.to = 0;
      if (!m.busy) begin
         rel = 1;
      end else begin
         rel  = d || (max_hold > 0 && m.cnt + 1 == max_hold);
         s.to = rel && !d;
      end
      if (!rel) begin
         s.cnt = m.cnt + 1;
      end else if (w >= 0) begin
         s.busy = 1; s.holder = w; s.ptr = (w + 1) % n; s.cnt = 0;
      end else begin
         s.busy = 0; s.cnt = 0;
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_all();
      bus_a.req = 4'b0000; bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (bus_a.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus_a.gnt); end
      checks++; if (bus_a.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid: got %b want 0", bus_a.gnt_valid); end
      checks++; if (bus_a.gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_gnt_idx: got %0d want 0", bus_a.gnt_idx); end
      checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus_a.timeout); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bus_a.req = 4'b0100; tick();
      checks++; if (bus_a.gnt !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", bus_a.gnt); end
      checks++; if (bus_a.gnt_idx !== 2'd2) begin errors++; $display("FAIL single_idx: got %0d want 2", bus_a.gnt_idx); end
      checks++; if (bus_a.gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus_a.gnt_valid); end
      tick(); tick();
      checks++; if (bus_a.gnt !== 4'b0100) begin errors++; $display("FAIL single_hold: got %b want 0100", bus_a.gnt); end
      bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0100 || bus_a.gnt_valid !== 1'b1) begin errors++; $display("FAIL single_regrant: got %b/%b want 0100/1", bus_a.gnt, bus_a.gnt_valid); end
      // ptr must now be 3: with every requester active, 3 wins next.
      bus_a.req = 4'b1111; bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b1000) begin errors++; $display("FAIL single_ptr3: got %b want 1000", bus_a.gnt); end
      release_all();
      checks++; if (bus_a.gnt !== 4'b0000 || bus_a.gnt_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b/%b want 0000/0", bus_a.gnt, bus_a.gnt_valid); end
   endtask

   task automatic test_contention();
      logic [3:0] exp_g;
      bus_a.req = 4'b1111; tick();
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << (i % 4);
         checks++; if (bus_a.gnt !== exp_g || !$onehot(bus_a.gnt)) begin errors++; $display("FAIL contention_order[%0d]: got %b want %b", i, bus_a.gnt, exp_g); end
         tick();
         checks++; if (bus_a.gnt !== exp_g) begin errors++; $display("FAIL contention_hold[%0d]: got %b want %b", i, bus_a.gnt, exp_g); end
         if (i < 4) begin
            bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
         end
      end
      release_all();
   endtask

   task automatic test_wrap();
      bus_a.req = 4'b0100; tick();
      checks++; if (bus_a.gnt !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b want 0100", bus_a.gnt); end
      bus_a.req = 4'b0011; bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0001) begin errors++; $display("FAIL wrap_to0: got %b want 0001", bus_a.gnt); end
      tick();
      bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL wrap_to1: got %b want 0010", bus_a.gnt); end
      release_all();
   endtask

   task automatic test_watchdog();
      bus_a.req = 4'b0010; tick();
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL wdog_grant: got %b want 0010", bus_a.gnt); end
      bus_a.req = 4'b0011;
      for (int e = 1; e < 5; e++) begin
         tick();
         checks++; if (bus_a.gnt !== 4'b0010 || bus_a.timeout !== 1'b0) begin errors++; $display("FAIL wdog_hold[%0d]: got %b/%b want 0010/0", e, bus_a.gnt, bus_a.timeout); end
      end
      tick();
      checks++; if (bus_a.gnt !== 4'b0001 || bus_a.timeout !== 1'b1) begin errors++; $display("FAIL wdog_expire: got %b/%b want 0001/1", bus_a.gnt, bus_a.timeout); end
      tick();
      checks++; if (bus_a.gnt !== 4'b0001 || bus_a.timeout !== 1'b0) begin errors++; $display("FAIL wdog_pulse_end: got %b/%b want 0001/0", bus_a.gnt, bus_a.timeout); end
      bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL wdog_regrant1: got %b want 0010", bus_a.gnt); end
      repeat (4) tick();
      bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0001 || bus_a.timeout !== 1'b0) begin errors++; $display("FAIL wdog_done_wins: got %b/%b want 0001/0", bus_a.gnt, bus_a.timeout); end
      release_all();
   endtask

   task automatic test_holder_drop();
      bus_a.req = 4'b0010; tick();
      bus_a.req = 4'b0000; tick(); tick();
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL drop_hold: got %b want 0010", bus_a.gnt); end
      bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0000 || bus_a.gnt_valid !== 1'b0 || bus_a.gnt_idx !== 2'd1) begin
         errors++; $display("FAIL drop_idle: got %b/%b/%0d want 0000/0/1", bus_a.gnt, bus_a.gnt_valid, bus_a.gnt_idx);
      end
   endtask

   task automatic test_reset_mid();
      bus_a.req = 4'b0010; tick();
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_setup: got %b want 0010", bus_a.gnt); end
      #3 rst = 1'b1;
      #1;
      checks++; if (bus_a.gnt !== 4'b0000 || bus_a.gnt_valid !== 1'b0 || bus_a.gnt_idx !== 2'd0 || bus_a.timeout !== 1'b0) begin
         errors++; $display("FAIL rstmid_async: got %b/%b/%0d/%b want 0000/0/0/0", bus_a.gnt, bus_a.gnt_valid, bus_a.gnt_idx, bus_a.timeout);
      end
      tick(); rst = 1'b0;
      bus_a.req = 4'b1010; tick();
      checks++; if (bus_a.gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_ptr0: got %b want 0010", bus_a.gnt); end
      release_all();
      bus_a.done = 1'b1; tick(); tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 4'b0000 || bus_a.timeout !== 1'b0) begin errors++; $display("FAIL stray_done: got %b/%b want 0000/0", bus_a.gnt, bus_a.timeout); end
      bus_a.req = 4'b1111; tick();
      checks++; if (bus_a.gnt !== 4'b0100) begin errors++; $display("FAIL stray_ptr: got %b want 0100", bus_a.gnt); end
      release_all();
   endtask

   task automatic test_random();
      mdl_t     ma, mb;
      bit [7:0] ra, rb, eg;
      bit       da, db;
      #2 rst = 1'b1;
      bus_a.req = '0; bus_a.done = 1'b0; bus_b.req = '0; bus_b.done = 1'b0;
      tick(); rst = 1'b0;
      ma = mdl_reset(); mb = mdl_reset();
      for (int c = 0; c < 3000; c++) begin
         ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 15));
         rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 31));
         da = ($urandom_range(0, 5) == 0);
         db = ($urandom_range(0, 3) == 0);
         bus_a.req = ra[3:0]; bus_a.done = da;
         bus_b.req = rb[4:0]; bus_b.done = db;
         tick();
         ma = mdl_step(ma, 4, 5, ra, da);
         mb = mdl_step(mb, 5, 0, rb, db);
         eg = ma.busy ? (8'd1 << ma.holder) : 8'd0;
         checks++; if ({4'b0, bus_a.gnt} !== eg || bus_a.gnt_idx !== 2'(ma.holder) || bus_a.gnt_valid !== ma.busy || bus_a.timeout !== ma.to) begin
            errors++; $display("FAIL rand_a[%0d]: got gnt=%b idx=%0d v=%b to=%b want gnt=%b idx=%0d v=%b to=%b",
                               c, bus_a.gnt, bus_a.gnt_idx, bus_a.gnt_valid, bus_a.timeout, eg[3:0], ma.holder, ma.busy, ma.to);
         end
         eg = mb.busy ? (8'd1 << mb.holder) : 8'd0;
         checks++; if ({3'b0, bus_b.gnt} !== eg || bus_b.gnt_idx !== 3'(mb.holder) || bus_b.gnt_valid !== mb.busy || bus_b.timeout !== 1'b0) begin
            errors++; $display("FAIL rand_b[%0d]: got gnt=%b idx=%0d v=%b to=%b want gnt=%b idx=%0d v=%b to=0",
                               c, bus_b.gnt, bus_b.gnt_idx, bus_b.gnt_valid, bus_b.timeout, eg[4:0], mb.holder, mb.busy);
         end
      end
   endtask

   initial begin
      bus_a.req = '0; bus_a.done = 1'b0;
      bus_b.req = '0; bus_b.done = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_watchdog();
      test_holder_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
